// File: rtl/speed_loop_mux_if.sv
// rtl/speed_loop_mux_if.sv - control and data bundle between speed_loop_mux and its host
interface speed_loop_mux_if #(
    parameter int NCH     = 2,
    parameter int QEI_RES = 16,
    parameter int PWM_RES = 10
);
    logic                   en;
    logic                   clr_int;
    logic [NCH*QEI_RES-1:0] qei_in;
    logic [NCH*16-1:0]      setpoint;
    logic [7:0]             kp;
    logic [7:0]             ki;
    logic [NCH*PWM_RES-1:0] duty;
    logic [NCH-1:0]         dir;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (output en, clr_int, qei_in, setpoint, kp, ki,
                    input  duty, dir, busy, done, overrun);
    modport slave  (input  en, clr_int, qei_in, setpoint, kp, ki,
                    output duty, dir, busy, done, overrun);
endinterface

// File: rtl/speed_loop_mux.sv
// rtl/speed_loop_mux.sv - time-multiplexed PI wheel speed loop, qei deltas in, pwm duty/dir out
module speed_loop_mux #(
    parameter int NCH     = 2,
    parameter int QEI_RES = 16,
    parameter int PWM_RES = 10,
    parameter int PERIOD  = 48000,
    parameter int SHIFT   = 6,
    parameter int ISAT    = 32767
) (
    input  logic            clk,
    input  logic            rst,
    speed_loop_mux_if.slave bus
);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int EW  = ((QEI_RES > 16) ? QEI_RES : 16) + 2;
    localparam int IW  = 32;
    localparam int BW  = (EW > IW) ? EW : IW;
    localparam int AW  = BW + 10;

    localparam logic signed [BW:0]      ISAT_P = (BW+1)'(ISAT);
    localparam logic signed [BW:0]      ISAT_N = -ISAT_P;
    localparam logic [PWM_RES-1:0]      DMAX   = '1;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ERR, S_MULP, S_MULI, S_WRITE} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [PCW-1:0]             cnt_q, cnt_d;
    logic [QEI_RES-1:0]         delta_q, delta_d;
    logic signed [EW-1:0]       e_q, e_d;
    logic signed [AW-1:0]       p_q, p_d;
    logic signed [AW-1:0]       acc_q, acc_d;
    logic [QEI_RES-1:0]         prev_q [NCH];
    logic [QEI_RES-1:0]         prev_d [NCH];
    logic signed [IW-1:0]       integ_q [NCH];
    logic signed [IW-1:0]       integ_d [NCH];
    logic [PWM_RES-1:0]         duty_q [NCH];
    logic [PWM_RES-1:0]         duty_d [NCH];
    logic [NCH-1:0]             dir_q, dir_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;
    logic                       primed_q, primed_d;

    logic                       tick;
    logic [QEI_RES-1:0]         qei_now;
    logic signed [15:0]         sp_now;
    logic signed [BW:0]         integ_sum;
    logic signed [IW-1:0]       integ_new;
    logic [7:0]                 mul_a;
    logic signed [BW-1:0]       mul_b;
    logic signed [AW-1:0]       mul_p;
    logic signed [AW-1:0]       u_w;
    logic [AW-1:0]              mag;
    logic [PWM_RES-1:0]         duty_new;
    logic [NCH*PWM_RES-1:0]     duty_flat;

    // Shared datapath: one multiplier serves kp*e in MULP and ki*I in MULI.
    always_comb begin
        tick      = bus.en && (cnt_q == PCW'(PERIOD - 1));
        qei_now   = bus.qei_in[32'(ch_q)*QEI_RES +: QEI_RES];
        sp_now    = bus.setpoint[32'(ch_q)*16 +: 16];
        integ_sum = (BW+1)'(integ_q[ch_q]) + (BW+1)'(e_q);
        if (integ_sum > ISAT_P)
            integ_new = IW'(ISAT_P);
        else if (integ_sum < ISAT_N)
            integ_new = IW'(ISAT_N);
        else
            integ_new = IW'(integ_sum);
        mul_a    = (state_q == S_MULI) ? bus.ki : bus.kp;
        mul_b    = (state_q == S_MULI) ? BW'(integ_new) : BW'(e_q);
        mul_p    = AW'($signed({1'b0, mul_a})) * AW'(mul_b);
        u_w      = acc_q >>> SHIFT;
        mag      = u_w[AW-1] ? AW'(-u_w) : AW'(u_w);
        duty_new = (mag > AW'(DMAX)) ? DMAX : mag[PWM_RES-1:0];
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        delta_d   = delta_q;
        e_d       = e_q;
        p_d       = p_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        integ_d   = integ_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q || (tick && (state_q != S_IDLE));
        primed_d  = primed_q;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_LATCH;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            S_LATCH: begin
                delta_d      = qei_now - prev_q[ch_q];
                prev_d[ch_q] = qei_now;
                state_d      = S_ERR;
            end
            S_ERR: begin
                e_d     = EW'(sp_now) - EW'($signed(delta_q));
                state_d = S_MULP;
            end
            S_MULP: begin
                p_d     = mul_p;
                state_d = S_MULI;
            end
            S_MULI: begin
                if (primed_q)
                    integ_d[ch_q] = integ_new;
                acc_d   = p_q + mul_p;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (primed_q) begin
                    duty_d[ch_q] = duty_new;
                    dir_d[ch_q]  = u_w[AW-1];
                end
                if (ch_q == CW'(NCH - 1)) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    primed_d = 1'b1;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_LATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.clr_int) begin
            for (int k = 0; k < NCH; k++)
                integ_d[k] = '0;
        end

        // Disabling the loop abandons any sweep and forces the next one to re-prime.
        if (!bus.en) begin
            cnt_d    = '0;
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            primed_d = 1'b0;
            dir_d    = '0;
            for (int k = 0; k < NCH; k++) begin
                duty_d[k]  = '0;
                integ_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            delta_q   <= '0;
            e_q       <= '0;
            p_q       <= '0;
            acc_q     <= '0;
            prev_q    <= '{default: '0};
            integ_q   <= '{default: '0};
            duty_q    <= '{default: '0};
            dir_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            primed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            delta_q   <= delta_d;
            e_q       <= e_d;
            p_q       <= p_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            integ_q   <= integ_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            primed_q  <= primed_d;
        end
    end

    always_comb begin
        duty_flat = '0;
        for (int k = 0; k < NCH; k++)
            duty_flat[k*PWM_RES +: PWM_RES] = duty_q[k];
    end

    assign bus.duty    = duty_flat;
    assign bus.dir     = dir_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule
